// File: rtl/ps2_frame_receiver.sv
// PS/2-style serial frame receiver: synchronised device pins, frame FSM with
// parity/framing/timeout classification, and a show-ahead frame FIFO.
module ps2_frame_receiver #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PARITY_MODE = 1,
  parameter logic [15:0] OVER_TIME   = 16'd1000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          peripheral_clock,
  input  logic                          device_clock,
  input  logic                          device_data,
  input  logic                          read_strobe,
  input  logic                          clear_error,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          error_flag,
  output logic [1:0]                    error_code,
  output logic                          overflow_flag,
  output logic                          inhibit
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned TW = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // [0]/[1] are the synchroniser stages, [2] is the edge-detect copy
  logic [2:0] dclk_sh;
  logic [1:0] ddat_sh;
  logic [2:0] pclk_sh;

  state_t                state;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] data_sr;
  logic                  parity_ok;
  logic [TW-1:0]         tcnt;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  logic                  fall_c;
  logic                  prise_c;
  logic                  dat_c;
  logic                  stop_fall_c;
  logic                  timeout_c;
  logic                  push_req_c;
  logic                  pop_c;
  logic                  push_c;
  logic                  full_c;
  logic                  overflow_c;
  logic [CW-1:0]         count_next_c;
  logic [PW-1:0]         rd_next_c;
  logic [DATA_WIDTH-1:0] head_next_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dclk_sh <= '0;
      ddat_sh <= '0;
      pclk_sh <= '0;
    end else begin
      dclk_sh <= {dclk_sh[1:0], device_clock};
      ddat_sh <= {ddat_sh[0], device_data};
      pclk_sh <= {pclk_sh[1:0], peripheral_clock};
    end
  end

  always_comb begin
    fall_c       = dclk_sh[2] & ~dclk_sh[1];
    prise_c      = pclk_sh[1] & ~pclk_sh[2];
    dat_c        = ddat_sh[1];
    stop_fall_c  = (state == S_STOP) && fall_c;
    timeout_c    = (state != S_IDLE) && !fall_c && prise_c && (tcnt == OVER_TIME - 16'd1);
    push_req_c   = stop_fall_c && dat_c && parity_ok;
    full_c       = (fifo_count == CW'(FIFO_DEPTH));
    pop_c        = read_strobe && (fifo_count != '0);
    push_c       = push_req_c && (!full_c || pop_c);
    overflow_c   = push_req_c && full_c && !pop_c;
    count_next_c = fifo_count + CW'(push_c) - CW'(pop_c);
    rd_next_c    = rd_ptr + PW'(pop_c);
    // A frame written into an otherwise-empty FIFO becomes the head directly
    if (count_next_c == '0) begin
      head_next_c = '0;
    end else if ((fifo_count - CW'(pop_c)) == '0) begin
      head_next_c = data_sr;
    end else begin
      head_next_c = mem[rd_next_c];
    end
  end

  // Frame state machine
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      data_sr   <= '0;
      parity_ok <= 1'b0;
      busy      <= 1'b0;
    end else if (timeout_c) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else if (fall_c) begin
      case (state)
        S_IDLE: begin
          if (!dat_c) begin
            state     <= S_DATA;
            bit_cnt   <= '0;
            parity_ok <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_DATA: begin
          data_sr <= {dat_c, data_sr[DATA_WIDTH-1:1]};
          bit_cnt <= bit_cnt + BW'(1);
          if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
            state <= (PARITY_MODE == 0) ? S_STOP : S_PARITY;
          end
        end
        S_PARITY: begin
          parity_ok <= ((^{data_sr, dat_c}) == (PARITY_MODE == 1));
          state     <= S_STOP;
        end
        S_STOP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Inter-edge timeout counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if ((state == S_IDLE) || fall_c) begin
      tcnt <= '0;
    end else if (prise_c && (tcnt < OVER_TIME)) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // Sticky error and overflow status; a new event beats clear_error
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      error_flag    <= 1'b0;
      error_code    <= 2'd0;
      overflow_flag <= 1'b0;
    end else begin
      if (timeout_c) begin
        error_flag <= 1'b1;
        error_code <= 2'd3;
      end else if (stop_fall_c && !dat_c) begin
        error_flag <= 1'b1;
        error_code <= 2'd2;
      end else if (stop_fall_c && !parity_ok) begin
        error_flag <= 1'b1;
        error_code <= 2'd1;
      end else if (clear_error) begin
        error_flag <= 1'b0;
        error_code <= 2'd0;
      end
      if (overflow_c) begin
        overflow_flag <= 1'b1;
      end else if (clear_error) begin
        overflow_flag <= 1'b0;
      end
    end
  end

  // Frame FIFO with registered show-ahead head
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      inhibit    <= 1'b0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= data_sr;
      end
      wr_ptr     <= wr_ptr + PW'(push_c);
      rd_ptr     <= rd_next_c;
      fifo_count <= count_next_c;
      data_out   <= head_next_c;
      data_valid <= (count_next_c != '0);
      inhibit    <= (count_next_c == CW'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Randomised self-checking bench for ps2_frame_receiver against a queue-based
// model of the frame rules (odd parity, 8-bit main DUT; 7-bit no-parity DUT).
module tb_ps2_frame_receiver;

  localparam int unsigned DEPTH = 4;
  localparam int HALF = 6;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic pclk = 1'b0;
  logic dclk [2];
  logic ddat [2];
  logic rs [2];
  logic ce [2];

  logic [7:0] data_out;
  logic       data_valid;
  logic [2:0] fifo_count;
  logic       busy, error_flag, overflow_flag, inhibit;
  logic [1:0] error_code;

  logic [6:0] data_out7;
  logic       data_valid7;
  logic [2:0] fifo_count7;
  logic       busy7, error_flag7, overflow_flag7, inhibit7;
  logic [1:0] error_code7;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q [$];
  logic       exp_flag = 1'b0;
  logic [1:0] exp_code = 2'd0;
  logic       exp_ovf = 1'b0;

  ps2_frame_receiver #(.DATA_WIDTH(8), .PARITY_MODE(1), .OVER_TIME(16'd16), .FIFO_DEPTH(4)) u_dut (
    .clock(clock), .reset_n(reset_n), .peripheral_clock(pclk),
    .device_clock(dclk[0]), .device_data(ddat[0]),
    .read_strobe(rs[0]), .clear_error(ce[0]),
    .data_out(data_out), .data_valid(data_valid), .fifo_count(fifo_count), .busy(busy),
    .error_flag(error_flag), .error_code(error_code), .overflow_flag(overflow_flag),
    .inhibit(inhibit)
  );

  ps2_frame_receiver #(.DATA_WIDTH(7), .PARITY_MODE(0), .OVER_TIME(16'd16), .FIFO_DEPTH(4)) u_dut7 (
    .clock(clock), .reset_n(reset_n), .peripheral_clock(pclk),
    .device_clock(dclk[1]), .device_data(ddat[1]),
    .read_strobe(rs[1]), .clear_error(ce[1]),
    .data_out(data_out7), .data_valid(data_valid7), .fifo_count(fifo_count7), .busy(busy7),
    .error_flag(error_flag7), .error_code(error_code7), .overflow_flag(overflow_flag7),
    .inhibit(inhibit7)
  );

  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: run did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Model: expected FIFO-side outputs {data_valid, fifo_count, data_out, inhibit}
  function automatic logic [12:0] exp_fifo();
    logic [7:0] h;
    h = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    return {exp_q.size() != 0, 3'(exp_q.size()), h, exp_q.size() == DEPTH};
  endfunction

  function automatic logic [3:0] exp_err();
    return {exp_flag, exp_code, exp_ovf};
  endfunction

  function automatic logic good_pbit(input logic [7:0] d);
    return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic model_frame(input logic [7:0] d, input logic pbit, input logic stop, input bit pop);
    if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
    if (!stop) begin
      exp_flag = 1'b1; exp_code = 2'd2;
    end else if ((($countones(d) + (pbit ? 1 : 0)) % 2) != 1) begin
      exp_flag = 1'b1; exp_code = 2'd1;
    end else if (exp_q.size() < DEPTH) begin
      exp_q.push_back(d);
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic model_read();
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic drive_bit(input int idx, input logic b, input int npulse);
    ddat[idx] = b;
    wait_n(HALF);
    dclk[idx] = 1'b0;
    wait_n(HALF);
    for (int i = 0; i < npulse; i++) begin
      pclk = 1'b1; wait_n(4);
      pclk = 1'b0; wait_n(4);
    end
    dclk[idx] = 1'b1;
  endtask

  // Full frame; pop_at_push raises read_strobe in the cycle the frame is pushed
  task automatic send_frame(input int idx, input logic [8:0] d, input int nbits, input bit has_par,
                            input logic pbit, input logic stop, input int npulse, input bit pop_at_push);
    drive_bit(idx, 1'b0, npulse);
    for (int i = 0; i < nbits; i++) drive_bit(idx, d[i], npulse);
    if (has_par) drive_bit(idx, pbit, npulse);
    ddat[idx] = stop;
    wait_n(HALF);
    dclk[idx] = 1'b0;
    if (pop_at_push) begin
      wait_n(2); rs[idx] = 1'b1;
      wait_n(1); rs[idx] = 1'b0;
      wait_n(HALF - 3);
    end else begin
      wait_n(HALF);
    end
    dclk[idx] = 1'b1;
    wait_n(HALF);
  endtask

  task automatic pulse_read(input int idx);
    rs[idx] = 1'b1; wait_n(1);
    rs[idx] = 1'b0; wait_n(1);
  endtask

  task automatic clear_err();
    ce[0] = 1'b1; wait_n(1);
    ce[0] = 1'b0; wait_n(1);
    exp_flag = 1'b0; exp_code = 2'd0; exp_ovf = 1'b0;
  endtask

  task automatic test_reset();
    wait_n(3);
    checks++;
    if ({data_out, data_valid, fifo_count, busy, error_flag, error_code, overflow_flag, inhibit} !== 18'h0) begin
      failures++;
      $display("FAIL reset_in: got %h exp 0", {data_out, data_valid, fifo_count, busy, error_flag, error_code, overflow_flag, inhibit});
    end
    reset_n = 1'b1;
    wait_n(5);
    checks++;
    if ({data_out, data_valid, fifo_count, busy, error_flag, error_code, overflow_flag, inhibit} !== 18'h0) begin
      failures++;
      $display("FAIL reset_after: got %h exp 0", {data_out, data_valid, fifo_count, busy, error_flag, error_code, overflow_flag, inhibit});
    end
    checks++;
    if ({data_out7, data_valid7, fifo_count7, busy7, error_flag7, error_code7, overflow_flag7, inhibit7} !== 17'h0) begin
      failures++;
      $display("FAIL reset_w7: got %h exp 0", {data_out7, data_valid7, fifo_count7, busy7, error_flag7, error_code7, overflow_flag7, inhibit7});
    end
  endtask

  task automatic test_basic();
    send_frame(0, 9'h01C, 8, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    model_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({data_valid, fifo_count, data_out, inhibit} !== exp_fifo()) begin
      failures++; $display("FAIL basic_fifo: got %h exp %h", {data_valid, fifo_count, data_out, inhibit}, exp_fifo());
    end
    checks++;
    if ({busy, error_flag, error_code, overflow_flag} !== {1'b0, exp_err()}) begin
      failures++; $display("FAIL basic_status: got %h exp %h", {busy, error_flag, error_code, overflow_flag}, {1'b0, exp_err()});
    end
    pulse_read(0);
    model_read();
    checks++;
    if ({data_valid, fifo_count, data_out, inhibit} !== exp_fifo()) begin
      failures++; $display("FAIL basic_pop: got %h exp %h", {data_valid, fifo_count, data_out, inhibit}, exp_fifo());
    end
  endtask

  task automatic test_parity_error();
    send_frame(0, 9'h01C, 8, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    model_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag} !== {exp_fifo(), exp_err()}) begin
      failures++; $display("FAIL parity_err: got %h exp %h", {data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag}, {exp_fifo(), exp_err()});
    end
    clear_err();
    checks++;
    if ({error_flag, error_code, overflow_flag} !== exp_err()) begin
      failures++; $display("FAIL parity_clear: got %h exp %h", {error_flag, error_code, overflow_flag}, exp_err());
    end
  endtask

  task automatic test_framing();
    send_frame(0, 9'h05A, 8, 1'b1, good_pbit(8'h5A), 1'b1, 0, 1'b0);
    model_frame(8'h5A, good_pbit(8'h5A), 1'b1, 1'b0);
    send_frame(0, 9'h0F0, 8, 1'b1, good_pbit(8'hF0), 1'b0, 0, 1'b0);
    model_frame(8'hF0, good_pbit(8'hF0), 1'b0, 1'b0);
    checks++;
    if ({data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag} !== {exp_fifo(), exp_err()}) begin
      failures++; $display("FAIL framing_err: got %h exp %h", {data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag}, {exp_fifo(), exp_err()});
    end
    clear_err();
  endtask

  task automatic test_width7();
    logic [6:0] d2;
    d2 = 7'($urandom);
    send_frame(1, 9'h055, 7, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    checks++;
    if ({data_valid7, fifo_count7, data_out7, error_flag7} !== {1'b1, 3'd1, 7'h55, 1'b0}) begin
      failures++; $display("FAIL w7_first: got %h exp %h", {data_valid7, fifo_count7, data_out7, error_flag7}, {1'b1, 3'd1, 7'h55, 1'b0});
    end
    send_frame(1, {2'b00, d2}, 7, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    pulse_read(1);
    checks++;
    if ({data_valid7, fifo_count7, data_out7, error_flag7} !== {1'b1, 3'd1, d2, 1'b0}) begin
      failures++; $display("FAIL w7_second: got %h exp %h", {data_valid7, fifo_count7, data_out7, error_flag7}, {1'b1, 3'd1, d2, 1'b0});
    end
  endtask

  task automatic test_timeout_boundary();
    logic [7:0] d;
    d = 8'($urandom);
    send_frame(0, {1'b0, d}, 8, 1'b1, good_pbit(d), 1'b1, 15, 1'b0);
    model_frame(d, good_pbit(d), 1'b1, 1'b0);
    checks++;
    if ({data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag} !== {exp_fifo(), exp_err()}) begin
      failures++; $display("FAIL slow_frame: got %h exp %h", {data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag}, {exp_fifo(), exp_err()});
    end
  endtask

  task automatic test_timeout();
    drive_bit(0, 1'b0, 0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'($urandom), 0);
    for (int i = 0; i < 15; i++) begin
      pclk = 1'b1; wait_n(4);
      pclk = 1'b0; wait_n(4);
    end
    checks++;
    if ({busy, error_flag, error_code} !== {1'b1, exp_flag, exp_code}) begin
      failures++; $display("FAIL timeout_early: got %h exp %h", {busy, error_flag, error_code}, {1'b1, exp_flag, exp_code});
    end
    pclk = 1'b1; wait_n(4);
    pclk = 1'b0; wait_n(2);
    exp_flag = 1'b1; exp_code = 2'd3;
    checks++;
    if ({busy, data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag} !== {1'b0, exp_fifo(), exp_err()}) begin
      failures++; $display("FAIL timeout_fire: got %h exp %h", {busy, data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag}, {1'b0, exp_fifo(), exp_err()});
    end
    send_frame(0, 9'h01C, 8, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    model_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag} !== {exp_fifo(), exp_err()}) begin
      failures++; $display("FAIL timeout_recover: got %h exp %h", {data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag}, {exp_fifo(), exp_err()});
    end
    clear_err();
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    while (exp_q.size() != 0) begin
      pulse_read(0);
      model_read();
    end
    clear_err();
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      send_frame(0, {1'b0, d}, 8, 1'b1, good_pbit(d), 1'b1, 0, 1'b0);
      model_frame(d, good_pbit(d), 1'b1, 1'b0);
      checks++;
      if ({data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag} !== {exp_fifo(), exp_err()}) begin
        failures++; $display("FAIL fill_%0d: got %h exp %h", i, {data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag}, {exp_fifo(), exp_err()});
      end
    end
    clear_err();
    d = 8'($urandom);
    send_frame(0, {1'b0, d}, 8, 1'b1, good_pbit(d), 1'b1, 0, 1'b1);
    model_frame(d, good_pbit(d), 1'b1, 1'b1);
    checks++;
    if ({data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag} !== {exp_fifo(), exp_err()}) begin
      failures++; $display("FAIL full_push_pop: got %h exp %h", {data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag}, {exp_fifo(), exp_err()});
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic pb, st;
    int np;
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      st = ($urandom_range(0, 7) != 0);
      pb = good_pbit(d) ^ ($urandom_range(0, 4) == 0);
      np = $urandom_range(0, 3);
      send_frame(0, {1'b0, d}, 8, 1'b1, pb, st, np, 1'b0);
      model_frame(d, pb, st, 1'b0);
      checks++;
      if ({busy, data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag} !== {1'b0, exp_fifo(), exp_err()}) begin
        failures++; $display("FAIL rand_%0d: got %h exp %h", n, {busy, data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag}, {1'b0, exp_fifo(), exp_err()});
      end
      if ($urandom_range(0, 2) == 0) begin
        pulse_read(0);
        model_read();
      end
      if ($urandom_range(0, 9) == 0) clear_err();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    while (exp_q.size() < 2) begin
      d = 8'($urandom);
      send_frame(0, {1'b0, d}, 8, 1'b1, good_pbit(d), 1'b1, 0, 1'b0);
      model_frame(d, good_pbit(d), 1'b1, 1'b0);
    end
    while (exp_q.size() > 2) begin
      pulse_read(0);
      model_read();
    end
    drive_bit(0, 1'b0, 0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'($urandom), 0);
    ddat[0] = 1'b1;
    wait_n(HALF);
    dclk[0] = 1'b0;
    wait_n(2);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({data_out, data_valid, fifo_count, busy, error_flag, error_code, overflow_flag, inhibit} !== 18'h0) begin
      failures++;
      $display("FAIL reset_async: got %h exp 0", {data_out, data_valid, fifo_count, busy, error_flag, error_code, overflow_flag, inhibit});
    end
    exp_q.delete();
    exp_flag = 1'b0; exp_code = 2'd0; exp_ovf = 1'b0;
    dclk[0] = 1'b1;
    wait_n(2);
    reset_n = 1'b1;
    wait_n(4);
    d = 8'($urandom);
    send_frame(0, {1'b0, d}, 8, 1'b1, good_pbit(d), 1'b1, 0, 1'b0);
    model_frame(d, good_pbit(d), 1'b1, 1'b0);
    checks++;
    if ({data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag} !== {exp_fifo(), exp_err()}) begin
      failures++; $display("FAIL reset_recover: got %h exp %h", {data_valid, fifo_count, data_out, inhibit, error_flag, error_code, overflow_flag}, {exp_fifo(), exp_err()});
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      dclk[i] = 1'b1; ddat[i] = 1'b1; rs[i] = 1'b0; ce[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_parity_error();
    test_framing();
    test_width7();
    test_timeout_boundary();
    test_timeout();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_frame_receiver.md
# ps2_frame_receiver

Parametrised receiver for PS/2-style serial frames clocked by the device: start bit, configurable data width, optional odd/even parity, stop bit. Frames are buffered in a show-ahead FIFO, and a timeout detects stalled frames. Error causes are classified, and the block requests a device clock hold (inhibit) when the FIFO is full. It sits between the keyboard/mouse pins and the peripheral bus interface in the KFPC-XT peripheral set.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame, LSB first; legal 5..9.
- PARITY_MODE, 1, 0 = none, 1 = odd, 2 = even.
- OVER_TIME, 16'd1000, peripheral_clock rising edges allowed between device clock falling edges inside a frame.
- FIFO_DEPTH, 4, frame buffer depth; power of two, 2..16.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- peripheral_clock  in  1  slow timebase for the timeout; asynchronous, synchronised internally.
- device_clock  in  1  PS/2 clock pin; asynchronous.
- device_data  in  1  PS/2 data pin; asynchronous.
- read_strobe  in  1  pops the FIFO head; one pop per cycle high.
- clear_error  in  1  clears error_flag, error_code and overflow_flag.
- data_out  out  DATA_WIDTH  FIFO head (show-ahead); 0 when empty.
- data_valid  out  1  FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  stored frames.
- busy  out  1  frame in progress (state != IDLE).
- error_flag  out  1  sticky; some frame was discarded for an error.
- error_code  out  2  cause of the most recent error: 0 none, 1 parity, 2 framing (stop bit 0), 3 timeout.
- overflow_flag  out  1  sticky; a good frame was dropped because the FIFO was full.
- inhibit  out  1  high while fifo_count == FIFO_DEPTH; drives the external clock-hold open-collector.

## Operation
- device_clock, device_data and peripheral_clock each pass a 2-FF synchroniser.
- Edges are detected against one further registered copy of each synchronised signal:
  - fall = prev & ~sync for device_clock.
  - rise = sync & ~prev for peripheral_clock.
- Data is always sampled from synchronised device_data in the fall cycle.
- State machine:
  - IDLE: on fall with data 0, go to DATA and clear bit_cnt. On fall with data 1, stay in IDLE; this is not an error.
  - DATA: each fall shifts data in LSB first and increments bit_cnt. After the DATA_WIDTH-th bit, go to PARITY, or to STOP if PARITY_MODE = 0.
  - PARITY: on fall, latch parity_ok and go to STOP.
    - Odd mode: data bits plus the parity bit contain an odd number of ones.
    - Even mode: they contain an even number of ones.
  - STOP: on fall, go to IDLE and classify the frame:
    - If the stop bit is 0: framing error.
    - Else if parity is not ok: parity error.
    - Else: push the frame if the FIFO has room, otherwise set overflow_flag and drop the frame.
- Timeout:
  - Counter is cleared in IDLE and on every fall.
  - Outside IDLE it increments on each peripheral rise and saturates at OVER_TIME.
  - Reaching OVER_TIME forces IDLE, discards the partial frame and sets error code 3.
- Error update: set error_flag to 1 and load error_code. If an error and clear_error occur in the same cycle, the error wins.
- FIFO:
  - Circular, with separate read and write pointers.
  - Push and pop in the same cycle: both take effect and count is unchanged, including at full. A push to a full FIFO with a simultaneous pop is accepted and is not an overflow.
  - Pop when empty is ignored.
- Reset mid-frame: returns to IDLE immediately and empties the FIFO.

## Timing
- Reset values: data_out 0, data_valid 0, fifo_count 0, busy 0, error_flag 0, error_code 0, overflow_flag 0, inhibit 0. All internal state and pointers are cleared.
- A pin edge produces fall in the 3rd clock cycle after it, measured when the pin is stable in setup at the first sync FF.
- Push happens on the rising edge that ends the stop-bit fall cycle. data_valid, fifo_count and data_out update on that edge, so they are visible the next cycle.
- busy rises on the edge ending the start-bit fall cycle and falls on the edge ending the stop-bit fall cycle or the timeout cycle.
- Pop: data_out shows the next entry from the cycle after read_strobe.
- inhibit is registered from fifo_count, with no extra delay beyond the count update.
- Timeout fires on the clock edge where the counter reaches OVER_TIME, i.e. at the OVER_TIME-th peripheral rise after the last fall.

## Test plan
- Defaults. Send frame 0x1C with parity 0 and stop 1 -> data_valid=1, data_out=8'h1C, fifo_count=1, error_flag=0. Pulse read_strobe -> data_valid=0.
- 0x1C with parity bit 1 -> no push, error_flag=1, error_code=1. clear_error -> flag and code return to 0.
- Stop bit 0 on 0xF0 -> error_code=2, FIFO unchanged. With PARITY_MODE=0 and DATA_WIDTH=7, frame 7'h55 -> data_out=7'h55, no parity bit expected.
- Stop device_clock after 4 data bits; OVER_TIME=16 -> error_code=3 at the 16th peripheral rise, busy=0. A following valid 0x1C is received normally.
- FIFO_DEPTH=4:
  - Send 4 frames -> inhibit=1, fifo_count=4.
  - 5th frame -> overflow_flag=1, head is still frame 1.
  - 5th frame repeated with read_strobe coinciding with its push -> no overflow, fifo_count stays 4.
- Assert reset_n low mid-data-bit with 2 entries in the FIFO -> all outputs at reset values asynchronously. The next full frame is received correctly.
